// File: rtl/serial_adder_if.sv
// Handshake and result bundle for the bit-serial adder: master drives the
// operand stream, slave returns the parallel result and status.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic             c_in;
  logic             bit_valid;
  logic             a_bit;
  logic             b_bit;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;
  logic             done;

  modport master (
    output start, c_in, bit_valid, a_bit, b_bit,
    input  sum, c_out, busy, done
  );

  modport slave (
    input  start, c_in, bit_valid, a_bit, b_bit,
    output sum, c_out, busy, done
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first operand bits are added one per accepted cycle
// and shifted into a parallel result, with a one-cycle done pulse at the end.
//
// state | meaning
// IDLE  | waiting for start; sum/c_out hold the last result
// ADD   | consuming operand bits whenever bit_valid is high
// DONE  | result valid, done high for this single cycle
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          n_reset,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("serial_adder: WIDTH must be in 2..32");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic sum_bit;
  logic maj_bit;

  assign sum_bit = bus.a_bit ^ bus.b_bit ^ carry_q;
  assign maj_bit = (bus.a_bit & bus.b_bit) | (bus.a_bit & carry_q) | (bus.b_bit & carry_q);

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          carry_d = bus.c_in;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = ADD;
          busy_d  = 1'b1;
        end
      end

      ADD: begin
        busy_d = 1'b1;
        if (bus.bit_valid) begin
          carry_d = maj_bit;
          sum_d   = {sum_bit, sum_q[WIDTH-1:1]};
          if (cnt_q == LAST) begin
            // Counter parks at LAST; it is reloaded by the next accepted start.
            cout_d  = maj_bit;
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sum   = sum_q;
  assign bus.c_out = cout_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vector table, random operations with random
// stalls against an arithmetic model, reset abort, and exhaustive WIDTH=2 sweep.
module tb_serial_adder;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(2)) bus2 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .n_reset(n_reset), .bus(bus8.slave));
  serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .n_reset(n_reset), .bus(bus2.slave));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    int         stall_after;
    int         stall_len;
    int         start_at;
    logic [7:0] exp_sum;
    logic       exp_cout;
    int         exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One WIDTH=8 operation. exp_done_c/exp_sum_c/exp_cout_c < 0 disables the
  // table cross-check; the arithmetic model is always checked.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input int stall_after, input int stall_len, input int start_at,
                      input bit rnd, input int exp_done_c, input int exp_sum_c,
                      input int exp_cout_c, input string nm);
    int   cyc, bi, stalls, stall_left;
    bit   seen;
    logic [8:0] full;
    full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    @(negedge clk);
    bus8.start     = 1'b1;
    bus8.c_in      = cin;
    bus8.bit_valid = 1'b0;
    bus8.a_bit     = 1'($urandom);
    bus8.b_bit     = 1'($urandom);
    cyc = 0; bi = 0; stalls = 0; stall_left = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus8.start = (cyc == start_at);
      bus8.c_in  = 1'($urandom);
      if (cyc == 1) chk({nm, "_busy_add"}, 32'(bus8.busy), 32'd1);
      if (bus8.done) begin
        seen = 1'b1;
        bus8.bit_valid = 1'b0;
        chk({nm, "_done_cycle"}, 32'(cyc), 32'(9 + stalls));
        chk({nm, "_sum"}, 32'(bus8.sum), 32'(full[7:0]));
        chk({nm, "_cout"}, 32'(bus8.c_out), 32'(full[8]));
        if (exp_done_c >= 0) chk({nm, "_tbl_done"}, 32'(cyc), 32'(exp_done_c));
        if (exp_sum_c >= 0)  chk({nm, "_tbl_sum"}, 32'(bus8.sum), 32'(exp_sum_c));
        if (exp_cout_c >= 0) chk({nm, "_tbl_cout"}, 32'(bus8.c_out), 32'(exp_cout_c));
      end else if (bi >= 8) begin
        bus8.bit_valid = 1'b0;
      end else if (stall_left > 0 || (rnd && $urandom_range(0, 3) == 0)) begin
        if (stall_left > 0) stall_left--;
        stalls++;
        bus8.bit_valid = 1'b0;
        bus8.a_bit     = 1'($urandom);
        bus8.b_bit     = 1'($urandom);
      end else begin
        bus8.bit_valid = 1'b1;
        bus8.a_bit     = a[bi];
        bus8.b_bit     = b[bi];
        if (bi == stall_after) stall_left = stall_len;
        bi++;
      end
    end
    if (!seen) chk({nm, "_done_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    bus8.start = 1'b0;
    chk({nm, "_done_pulse_end"}, 32'(bus8.done), 32'd0);
    chk({nm, "_busy_idle"}, 32'(bus8.busy), 32'd0);
    @(negedge clk);
    chk({nm, "_sum_hold"}, 32'(bus8.sum), 32'(full[7:0]));
    chk({nm, "_cout_hold"}, 32'(bus8.c_out), 32'(full[8]));
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic cin);
    int   cyc;
    bit   seen;
    logic [2:0] full;
    full = {1'b0, a} + {1'b0, b} + {2'd0, cin};
    @(negedge clk);
    bus2.start = 1'b1;
    bus2.c_in  = cin;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      bus2.start = 1'b0;
      if (bus2.done) begin
        seen = 1'b1;
        bus2.bit_valid = 1'b0;
        chk("w2_done_cycle", 32'(cyc), 32'd3);
        chk($sformatf("w2_sum_%0d_%0d_%0d", a, b, cin), 32'(bus2.sum), 32'(full[1:0]));
        chk($sformatf("w2_cout_%0d_%0d_%0d", a, b, cin), 32'(bus2.c_out), 32'(full[2]));
      end else if (cyc <= 2) begin
        bus2.bit_valid = 1'b1;
        bus2.a_bit     = a[cyc-1];
        bus2.b_bit     = b[cyc-1];
      end else begin
        bus2.bit_valid = 1'b0;
      end
    end
    if (!seen) chk("w2_done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int done_seen;
    vecs[0] = '{8'h00, 8'h00, 1'b0, -1, 0, -1, 8'h00, 1'b0, 9};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, -1, 0, -1, 8'h00, 1'b1, 9};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, -1, 0, -1, 8'h00, 1'b1, 9};
    vecs[3] = '{8'h3C, 8'h0F, 1'b0,  2, 3, -1, 8'h4B, 1'b0, 12};
    vecs[4] = '{8'h12, 8'h34, 1'b0, -1, 0,  4, 8'h46, 1'b0, 9};
    vecs[5] = '{8'h7F, 8'h80, 1'b1, -1, 0,  9, 8'h00, 1'b1, 9};
    vecs[6] = '{8'hFF, 8'h01, 1'b0, -1, 0, -1, 8'h00, 1'b1, 9};

    n_reset = 1'b0;
    bus8.start = 1'b0; bus8.c_in = 1'b0; bus8.bit_valid = 1'b0; bus8.a_bit = 1'b0; bus8.b_bit = 1'b0;
    bus2.start = 1'b0; bus2.c_in = 1'b0; bus2.bit_valid = 1'b0; bus2.a_bit = 1'b0; bus2.b_bit = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sum", 32'(bus8.sum), 32'd0);
    chk("rst_cout", 32'(bus8.c_out), 32'd0);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_busy_w2", 32'(bus2.busy), 32'd0);
    n_reset = 1'b1;

    for (int i = 0; i < 7; i++)
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].stall_after, vecs[i].stall_len,
           vecs[i].start_at, 1'b0, vecs[i].exp_done, int'(vecs[i].exp_sum),
           int'(vecs[i].exp_cout), $sformatf("vec%0d", i));

    // Abort mid-operation: bits 0..5 of 0xFF+0xFF, then async reset.
    @(negedge clk);
    bus8.start = 1'b1; bus8.c_in = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus8.start = 1'b0;
      bus8.bit_valid = 1'b1; bus8.a_bit = 1'b1; bus8.b_bit = 1'b1;
    end
    @(negedge clk);
    bus8.bit_valid = 1'b0;
    n_reset = 1'b0;
    #1;
    chk("abort_busy", 32'(bus8.busy), 32'd0);
    chk("abort_sum", 32'(bus8.sum), 32'd0);
    chk("abort_cout", 32'(bus8.c_out), 32'd0);
    chk("abort_done", 32'(bus8.done), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus8.done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    run8(8'h80, 8'h80, 1'b0, -1, 0, -1, 1'b0, 9, 8'h00, 1, "post_abort");

    for (int i = 0; i < 25; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      run8(ra, rb, 1'($urandom), -1, 0, int'($urandom_range(1, 14)), 1'b1, -1, -1, -1,
           $sformatf("rnd%0d", i));
    end

    for (int v = 0; v < 32; v++) begin
      logic [4:0] vv;
      vv = 5'(v);
      run2(vv[4:3], vv[2:1], vv[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
